invader_grid_display: RTL



---
 rtl/invader_grid_display_if.sv | 15 +
 rtl/invader_grid_display.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/invader_grid_display_if.sv
// vga_if: VGA pixel-stream bundle passed between the drawing stages.
// Fields: vcount/hcount (11-bit counters), vsync/hsync, vblnk/hblnk, rgb (12-bit).
// Modports: in (stage receives the stream), out (stage drives the stream).
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/invader_grid_display.sv
// invader_grid_display: draws the invader formation onto the VGA stream and
// owns the formation state (alive mask, march position, direction, frame).
// Ports:
//   clk65MHz, rst           pixel clock, synchronous active-high reset
//   vga_in / vga_out        pixel stream in, pixel stream out (3-cycle delay)
//   move_tick               advances the march by one step
//   kill_valid/row/col      clears one invader from the alive mask
//   rgb_pixel / pixel_addr  synchronous sprite ROM data / address
//   row_sel                 row index for per-row sprite selection
//   alive, grid_x, grid_y   formation state
//   all_dead, reached_bottom status flags
module invader_grid_display #(
    parameter int NUM_ROWS       = 5,
    parameter int NUM_COLS       = 10,
    parameter int INVADER_WIDTH  = 64,
    parameter int INVADER_HEIGHT = 48,
    parameter int H_SPACING      = 16,
    parameter int V_SPACING      = 16,
    parameter int X_INIT         = 100,
    parameter int Y_INIT         = 60,
    parameter int STEP_X         = 8,
    parameter int STEP_Y         = 16,
    parameter int X_MIN          = 0,
    parameter int X_MAX          = 1024,  // HOR_PIXELS of the 1024x768 mode
    parameter int Y_LIMIT        = 700
) (
    input  logic                              clk65MHz,
    input  logic                              rst,
    vga_if.in                                 vga_in,
    vga_if.out                                vga_out,
    input  logic                              move_tick,
    input  logic                              kill_valid,
    input  logic [$clog2(NUM_ROWS)-1:0]       kill_row,
    input  logic [$clog2(NUM_COLS)-1:0]       kill_col,
    input  logic [11:0]                       rgb_pixel,
    output logic [12:0]                       pixel_addr,
    output logic [$clog2(NUM_ROWS)-1:0]       row_sel,
    output logic [NUM_ROWS*NUM_COLS-1:0]      alive,
    output logic [10:0]                       grid_x,
    output logic [10:0]                       grid_y,
    output logic                              all_dead,
    output logic                              reached_bottom
);

    localparam int HP = INVADER_WIDTH + H_SPACING;
    localparam int VP = INVADER_HEIGHT + V_SPACING;
    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);

    typedef enum logic {RIGHT, LEFT} march_t;

    typedef struct packed {
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] rgb;
    } vga_t;

    march_t state, state_next;
    logic        frame, frame_next;
    logic [10:0] gx_next, gy_next;
    logic        rb_next;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] alive_2d, alive_next;
    logic [NUM_COLS-1:0] col_any;
    logic [NUM_ROWS-1:0] row_any;
    logic [CW-1:0] lcol, rcol;
    logic [RW-1:0] brow;
    logic [11:0]   bound_l, bound_r, bound_b;

    assign alive_2d = alive;

    // ---------------------------------------------------------------
    // Kill port: out-of-range indices are dropped, dead bits stay dead.
    // ---------------------------------------------------------------
    always_comb begin
        alive_next = alive_2d;
        if (kill_valid && int'(kill_row) < NUM_ROWS && int'(kill_col) < NUM_COLS)
            alive_next[kill_row][kill_col] = 1'b0;
    end

    // ---------------------------------------------------------------
    // Live bounds from the pre-edge mask.
    // ---------------------------------------------------------------
    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                if (alive_2d[r][c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
        lcol = '0;
        rcol = '0;
        brow = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--)
            if (col_any[c]) lcol = CW'(c);
        for (int c = 0; c < NUM_COLS; c++)
            if (col_any[c]) rcol = CW'(c);
        for (int r = 0; r < NUM_ROWS; r++)
            if (row_any[r]) brow = RW'(r);
        // 12-bit so the left-edge test cannot wrap below zero
        bound_l = {1'b0, grid_x} + 12'(int'(lcol) * HP);
        bound_r = {1'b0, grid_x} + 12'(int'(rcol) * HP + INVADER_WIDTH);
    end

    // ---------------------------------------------------------------
    // March FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_next = state;
        gx_next    = grid_x;
        gy_next    = grid_y;
        frame_next = frame;
        rb_next    = reached_bottom;
        bound_b    = '0;
        if (move_tick && !all_dead && !reached_bottom) begin
            frame_next = ~frame;
            case (state)
                RIGHT: begin
                    if (bound_r + 12'(STEP_X) > 12'(X_MAX)) begin
                        gy_next    = grid_y + 11'(STEP_Y);
                        state_next = LEFT;
                    end else begin
                        gx_next = grid_x + 11'(STEP_X);
                    end
                end
                LEFT: begin
                    if (bound_l < 12'(X_MIN + STEP_X)) begin
                        gy_next    = grid_y + 11'(STEP_Y);
                        state_next = RIGHT;
                    end else begin
                        gx_next = grid_x - 11'(STEP_X);
                    end
                end
                default: state_next = RIGHT;
            endcase
            // bottom edge judged on the post-update origin
            bound_b = {1'b0, gy_next} + 12'(int'(brow) * VP + INVADER_HEIGHT);
            if (bound_b >= 12'(Y_LIMIT))
                rb_next = 1'b1;
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state          <= RIGHT;
            frame          <= 1'b0;
            grid_x         <= 11'(X_INIT);
            grid_y         <= 11'(Y_INIT);
            alive          <= '1;
            all_dead       <= 1'b0;
            reached_bottom <= 1'b0;
        end else begin
            state          <= state_next;
            frame          <= frame_next;
            grid_x         <= gx_next;
            grid_y         <= gy_next;
            alive          <= alive_next;
            all_dead       <= (alive_next == '0);
            reached_bottom <= rb_next;
        end
    end

    // ---------------------------------------------------------------
    // Pixel pipeline, stage 1: locate the cell by compare, no divider.
    // ---------------------------------------------------------------
    vga_t          s0, s1, s2, s3;
    logic [11:0]   rel_h, rel_v;
    logic          col_hit, row_hit, hit;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [5:0]    rel_x, rel_y;
    logic          hit_s1, hit_s2;

    always_comb begin
        s0.vcount = vga_in.vcount;
        s0.vsync  = vga_in.vsync;
        s0.vblnk  = vga_in.vblnk;
        s0.hcount = vga_in.hcount;
        s0.hsync  = vga_in.hsync;
        s0.hblnk  = vga_in.hblnk;
        s0.rgb    = vga_in.rgb;
    end

    always_comb begin
        rel_h   = {1'b0, vga_in.hcount} - {1'b0, grid_x};
        rel_v   = {1'b0, vga_in.vcount} - {1'b0, grid_y};
        col_hit = 1'b0;
        row_hit = 1'b0;
        col     = '0;
        row     = '0;
        rel_x   = '0;
        rel_y   = '0;
        // each compare window is the sprite box only, so spacing never hits
        if (vga_in.hcount >= grid_x)
            for (int c = 0; c < NUM_COLS; c++)
                if (rel_h >= 12'(c * HP) && rel_h < 12'(c * HP + INVADER_WIDTH)) begin
                    col_hit = 1'b1;
                    col     = CW'(c);
                    rel_x   = 6'(rel_h - 12'(c * HP));
                end
        if (vga_in.vcount >= grid_y)
            for (int r = 0; r < NUM_ROWS; r++)
                if (rel_v >= 12'(r * VP) && rel_v < 12'(r * VP + INVADER_HEIGHT)) begin
                    row_hit = 1'b1;
                    row     = RW'(r);
                    rel_y   = 6'(rel_v - 12'(r * VP));
                end
        hit = col_hit && row_hit && alive_2d[row][col];
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            hit_s1     <= 1'b0;
            hit_s2     <= 1'b0;
            pixel_addr <= '0;
            row_sel    <= '0;
        end else begin
            s1         <= s0;
            hit_s1     <= hit;
            pixel_addr <= hit ? {frame, rel_y, rel_x} : 13'd0;
            row_sel    <= hit ? row : '0;
            // stage 2: ROM access in flight, carry timing and hit
            s2         <= s1;
            hit_s2     <= hit_s1;
            // stage 3: overlay; black sprite pixels are transparent
            s3         <= s2;
            if (!(s2.hblnk || s2.vblnk || !hit_s2 || rgb_pixel == 12'h000))
                s3.rgb <= rgb_pixel;
        end
    end

    assign vga_out.vcount = s3.vcount;
    assign vga_out.vsync  = s3.vsync;
    assign vga_out.vblnk  = s3.vblnk;
    assign vga_out.hcount = s3.hcount;
    assign vga_out.hsync  = s3.hsync;
    assign vga_out.hblnk  = s3.hblnk;
    assign vga_out.rgb    = s3.rgb;

endmodule
